// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm_if
// Description : Control bundle between the multicycle sequencer and the
//               RV32I datapath. The master side is the sequencer (reads the
//               instruction fields and flags, drives enables and selects);
//               the slave side is the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_control_fsm_if #(
  parameter int STATE_W = 4
);
  // Instruction fields and status from the datapath
  logic [6:0]         op;
  logic [2:0]         funct3;
  logic               funct7_5;
  logic               Zero;
  logic               mem_ready;

  // Enables and selects toward the datapath
  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic [1:0]         ResultSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ImmSrc;
  logic [2:0]         ALUControl;
  logic               illegal_instr;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  op, funct3, funct7_5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr, state_dbg
  );

  modport slave (
    output op, funct3, funct7_5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr, state_dbg
  );
endinterface
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Moore sequencing controller for the multicycle RV32I core.
//               Steps each instruction through fetch / decode / execute /
//               memory / writeback, drives every datapath enable and mux
//               select, and decodes ALUControl and ImmSrc internally.
//               Stalls in FETCH, MEMREAD and MEMWRITE until mem_ready.
// Options     : MC_JALR_EN - adds jalr support (states JALR_ADR = 11 and
//               JALR = 12). Without it jalr is reported as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm #(
  parameter int STATE_W = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mc_control_fsm_if.master   bus
);

  // --------------------------------------------------------------------------
  // Opcodes recognised by the sequencer
  // --------------------------------------------------------------------------
  localparam logic [6:0] c_OP_LW   = 7'b0000011;
  localparam logic [6:0] c_OP_SW   = 7'b0100011;
  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_I    = 7'b0010011;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;
  localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
`ifdef MC_JALR_EN
  localparam logic [6:0] c_OP_JALR = 7'b1100111;
`endif

  // ALU operation class requested by the current state
  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

  // Mux select encodings
  localparam logic [1:0] c_SRCA_PC    = 2'b00;
  localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
  localparam logic [1:0] c_SRCA_RD1   = 2'b10;
  localparam logic [1:0] c_SRCB_RD2   = 2'b00;
  localparam logic [1:0] c_SRCB_IMM   = 2'b01;
  localparam logic [1:0] c_SRCB_FOUR  = 2'b10;
  localparam logic [1:0] c_RES_ALUOUT = 2'b00;
  localparam logic [1:0] c_RES_DATA   = 2'b01;
  localparam logic [1:0] c_RES_ALURES = 2'b10;

  // State encoding is the implicit enum order: FETCH=0 ... BEQ=10,
  // then JALR_ADR=11 and JALR=12 when jalr support is built in.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_ALUWB,
    S_EXECUTEI,
    S_JAL,
    S_BEQ
`ifdef MC_JALR_EN
    ,
    S_JALR_ADR,
    S_JALR
`endif
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic       w_pc_update;
  logic       w_branch;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_illegal;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [2:0] w_funct_ctrl;
  logic [2:0] w_alu_control;
  logic [1:0] w_imm_src;
  logic       w_is_sub;

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-state control decode; unlisted outputs stay 0
  always_comb begin
    w_state_next = r_state;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    w_result_src = c_RES_ALUOUT;
    w_alu_src_a  = c_SRCA_PC;
    w_alu_src_b  = c_SRCB_RD2;
    w_alu_op     = c_ALUOP_ADD;

    case (r_state)
      S_FETCH: begin
        // PC+4 is written back to PC in the same cycle the IR captures
        w_alu_src_a  = c_SRCA_PC;
        w_alu_src_b  = c_SRCB_FOUR;
        w_result_src = c_RES_ALURES;
        w_adr_src    = 1'b0;
        w_ir_write   = bus.mem_ready;
        w_pc_update  = bus.mem_ready;
        w_state_next = bus.mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        // OldPC + imm lands in ALUOut as the branch/jump target
        w_alu_src_a = c_SRCA_OLDPC;
        w_alu_src_b = c_SRCB_IMM;
        case (bus.op)
          c_OP_LW,
          c_OP_SW:   w_state_next = S_MEMADR;
          c_OP_R:    w_state_next = S_EXECUTER;
          c_OP_I:    w_state_next = S_EXECUTEI;
          c_OP_JAL:  w_state_next = S_JAL;
          c_OP_BEQ:  w_state_next = S_BEQ;
`ifdef MC_JALR_EN
          c_OP_JALR: w_state_next = S_JALR_ADR;
`endif
          default: begin
            w_illegal    = 1'b1;
            w_state_next = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        w_alu_src_a  = c_SRCA_RD1;
        w_alu_src_b  = c_SRCB_IMM;
        w_state_next = (bus.op == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        w_adr_src    = 1'b1;
        w_result_src = c_RES_ALUOUT;
        w_state_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end

      S_MEMWB: begin
        w_result_src = c_RES_DATA;
        w_reg_write  = 1'b1;
        w_state_next = S_FETCH;
      end

      S_MEMWRITE: begin
        // Strobe stays up for the whole wait so the memory sees a stable write
        w_adr_src    = 1'b1;
        w_result_src = c_RES_ALUOUT;
        w_mem_write  = 1'b1;
        w_state_next = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end

      S_EXECUTER: begin
        w_alu_src_a  = c_SRCA_RD1;
        w_alu_src_b  = c_SRCB_RD2;
        w_alu_op     = c_ALUOP_FUNCT;
        w_state_next = S_ALUWB;
      end

      S_ALUWB: begin
        w_result_src = c_RES_ALUOUT;
        w_reg_write  = 1'b1;
        w_state_next = S_FETCH;
      end

      S_EXECUTEI: begin
        w_alu_src_a  = c_SRCA_RD1;
        w_alu_src_b  = c_SRCB_IMM;
        w_alu_op     = c_ALUOP_FUNCT;
        w_state_next = S_ALUWB;
      end

      S_JAL: begin
        // PC <- target held in ALUOut; ALU forms OldPC+4 for the link write
        w_alu_src_a  = c_SRCA_OLDPC;
        w_alu_src_b  = c_SRCB_FOUR;
        w_result_src = c_RES_ALUOUT;
        w_pc_update  = 1'b1;
        w_state_next = S_ALUWB;
      end

      S_BEQ: begin
        w_alu_src_a  = c_SRCA_RD1;
        w_alu_src_b  = c_SRCB_RD2;
        w_alu_op     = c_ALUOP_SUB;
        w_result_src = c_RES_ALUOUT;
        w_branch     = 1'b1;
        w_state_next = S_FETCH;
      end

`ifdef MC_JALR_EN
      S_JALR_ADR: begin
        // rs1 + imm into ALUOut, overwriting the decode-stage target
        w_alu_src_a  = c_SRCA_RD1;
        w_alu_src_b  = c_SRCB_IMM;
        w_state_next = S_JALR;
      end

      S_JALR: begin
        w_alu_src_a  = c_SRCA_OLDPC;
        w_alu_src_b  = c_SRCB_FOUR;
        w_result_src = c_RES_ALUOUT;
        w_pc_update  = 1'b1;
        w_state_next = S_ALUWB;
      end
`endif

      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  // Funct-driven ALU selection; only R-type may request subtract
  always_comb begin
    w_is_sub     = bus.op[5] & bus.funct7_5;
    w_funct_ctrl = 3'b000;
    case (bus.funct3)
      3'b000:  w_funct_ctrl = w_is_sub ? 3'b001 : 3'b000;
      3'b010:  w_funct_ctrl = 3'b101;
      3'b110:  w_funct_ctrl = 3'b011;
      3'b111:  w_funct_ctrl = 3'b010;
      default: w_funct_ctrl = 3'b000;
    endcase
  end

  // Final ALUControl from the operation class chosen by the state
  always_comb begin
    w_alu_control = 3'b000;
    case (w_alu_op)
      c_ALUOP_SUB:   w_alu_control = 3'b001;
      c_ALUOP_FUNCT: w_alu_control = w_funct_ctrl;
      default:       w_alu_control = 3'b000;
    endcase
  end

  // Immediate format follows the opcode regardless of state
  always_comb begin
    w_imm_src = 2'b00;
    case (bus.op)
      c_OP_SW:  w_imm_src = 2'b01;
      c_OP_BEQ: w_imm_src = 2'b10;
      c_OP_JAL: w_imm_src = 2'b11;
      default:  w_imm_src = 2'b00;
    endcase
  end

  // Write enables are masked while rst is high; selects already show FETCH
  assign bus.PCWrite       = ~rst & (w_pc_update | (w_branch & bus.Zero));
  assign bus.MemWrite      = ~rst & w_mem_write;
  assign bus.IRWrite       = ~rst & w_ir_write;
  assign bus.RegWrite      = ~rst & w_reg_write;
  assign bus.illegal_instr = ~rst & w_illegal;
  assign bus.AdrSrc        = w_adr_src;
  assign bus.ResultSrc     = w_result_src;
  assign bus.ALUSrcA       = w_alu_src_a;
  assign bus.ALUSrcB       = w_alu_src_b;
  assign bus.ImmSrc        = w_imm_src;
  assign bus.ALUControl    = w_alu_control;
  assign bus.state_dbg     = r_state;

endmodule
`default_nettype wire

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle sequencing controller for the RV32I core. Replaces the combinational single-cycle control unit when the datapath moves to a shared instruction/data memory with registered IR, OldPC, Data and ALUOut.
- Moore FSM steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath enables and mux selects. Decodes ALUControl and ImmSrc internally.
- Stalls on a memory ready handshake.

Parameters:
- STATE_W, 4, state register width (debug port width).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  7  instr[6:0] from registered IR
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR/OldPC capture enable
- RegWrite  out  1  register file write
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J (combinational from op)
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_instr  out  1  one-cycle pulse on unsupported opcode
- state_dbg  out  STATE_W  current state encoding

Behaviour:
- Reset: rst is asynchronous and active-high. Asserting it forces state to FETCH (0).
- While rst is high: PCWrite, MemWrite, IRWrite, RegWrite and illegal_instr are 0. AdrSrc, ALUSrcA, ALUSrcB and ResultSrc take their FETCH values. state_dbg = 0.
- If rst asserts mid-instruction, the instruction is abandoned with no partial register or memory write.
- Outputs are a function of state only, except:
  - mem_ready gating in FETCH and MEMWRITE.
  - PCWrite = PCUpdate | (Branch & Zero).
- Unlisted signals in each state are 0. Default ALUOp is add.
- States, encoding in order 0..10, and transitions:
  - FETCH: A=00, B=10, add, ResultSrc=10, AdrSrc=0, IRWrite=PCUpdate=mem_ready. Stay while !mem_ready; go to DECODE on mem_ready.
  - DECODE: A=01, B=01, add (precomputes branch target into ALUOut).
    - lw (0000011) or sw (0100011) -> MEMADR
    - R (0110011) -> EXECUTER
    - I-ALU (0010011) -> EXECUTEI
    - jal (1101111) -> JAL
    - beq (1100011) -> BEQ
    - any other opcode -> FETCH with illegal_instr=1 this cycle
  - MEMADR: A=10, B=01, add. lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready, then -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready. On mem_ready -> FETCH.
  - EXECUTER: A=10, B=00, ALUOp=funct -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - EXECUTEI: A=10, B=01, ALUOp=funct -> ALUWB.
  - JAL: A=01, B=10, add, ResultSrc=00, PCUpdate=1 -> ALUWB.
  - BEQ: A=10, B=00, sub, ResultSrc=00, Branch=1 -> FETCH.
- ALU decode:
  - ALUOp add -> 000; sub -> 001.
  - funct, funct3=000: sub if op[5] & funct7_5, else add.
  - funct3 010 -> 101 (slt), 110 -> 011 (or), 111 -> 010 (and); other funct3 -> 000.
- Latency with mem_ready tied 1: lw 5 cycles; sw, R, I and jal 4 cycles; beq 3 cycles. Each mem_ready=0 cycle adds one cycle.
- mem_ready is ignored in every state except FETCH, MEMREAD and MEMWRITE.

Optional Feature:
- Macro MC_JALR_EN.
- Defined: jalr (1100111) DECODE -> JALR_ADR (A=10, B=01, add) -> JALR (A=01, B=10, add, ResultSrc=00, PCUpdate=1) -> ALUWB. The PC receives rs1+imm from ALUOut and rd receives OldPC+4. Encodings 11 and 12. Instruction takes 5 cycles.
- Undefined: jalr is illegal (DECODE -> FETCH with illegal_instr pulse). The states are absent.

Test Plan:
- rst high mid-MEMWRITE with mem_ready=0 -> MemWrite drops immediately, state_dbg=0 and all enables 0 until release. First cycle after release is FETCH.
- lw x5,8(x0), mem_ready=1 -> state sequence 0,1,2,3,4,0. RegWrite=1 only in MEMWB with ResultSrc=01. ImmSrc=00.
- sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite high for 4 consecutive cycles with AdrSrc=1, then FETCH.
- sub (op 0110011, funct3 000, funct7_5=1) -> EXECUTER shows ALUControl=001. Same with funct7_5=0 gives 000. addi with instr[30]=1 gives 000.
- beq with Zero=1 -> PCWrite=1 in BEQ. With Zero=0 -> PCWrite=0. Both return to FETCH after 3 cycles.
- op 1110011 -> illegal_instr pulses exactly one cycle in DECODE and there is no RegWrite/MemWrite. jalr gives the same result unless MC_JALR_EN is defined, in which case the sequence is 0,1,11,12,7.
